// File: rtl/count_sequencer_pkg.sv
// count_seq_pkg
// Shared definitions for the count_sequencer slice: state encoding,
// state/sweep counter widths and a saturating increment helper.
// The PAUSED encoding is always declared; the sequencer only ever
// enters it when built with COUNT_SEQ_PAUSE_EN.
package count_seq_pkg;

  localparam int STATE_W     = 3;
  localparam int SWEEP_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    UP     = 3'd1,
    DOWN   = 3'd2,
    CHOOSE = 3'd3,
    PAUSED = 3'd4
  } state_t;

  // The sweep counter sticks at its maximum instead of wrapping.
  function automatic logic [SWEEP_CNT_W-1:0] sat_inc(input logic [SWEEP_CNT_W-1:0] v);
    return (v == {SWEEP_CNT_W{1'b1}}) ? v : v + SWEEP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/count_sequencer_rise_edge.sv
// rise_edge
// One-register rising-edge detector. The edge output is high for the
// cycle in which din is high and was low at the previous clk.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset (clears the history register)
//   din    in  level input
//   rise   out din high now and low one clk earlier
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer
// Sequencing controller for the up/down counter datapath. After a start
// press it runs AUTO_SWEEPS alternating sweeps (UP first), then waits in
// CHOOSE for the user to pick a direction, runs that single sweep and
// returns to IDLE. Abort returns to IDLE from any active state.
// Every button and the counter's finish flag are rising-edge detected.
// Optional feature macro: COUNT_SEQ_PAUSE_EN adds the pause input and the
// PAUSED state.
// Parameters:
//   AUTO_SWEEPS     automatic sweeps after start (1..15)
//   CHOOSE_TIMEOUT  clk cycles allowed in CHOOSE before giving up; 0 = never
//   TMO_W           width of the CHOOSE timeout counter
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           start button (level)
//   progressive     "count up" selection (level)
//   regressive      "count down" selection (level)
//   abort           stop button (level)
//   pause           pause toggle (level, COUNT_SEQ_PAUSE_EN only)
//   finish          counter terminal flag (level)
//   enable          counter run enable
//   forward         1 = count up, 0 = count down
//   busy            high outside IDLE
//   choose          high in CHOOSE
//   sweep_cnt       completed sweeps since last start (saturating)
//   state_o         current state encoding
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int AUTO_SWEEPS    = 2,
  parameter int CHOOSE_TIMEOUT = 0,
  parameter int TMO_W          = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   progressive,
  input  logic                   regressive,
  input  logic                   abort,
`ifdef COUNT_SEQ_PAUSE_EN
  input  logic                   pause,
`endif
  input  logic                   finish,
  output logic                   enable,
  output logic                   forward,
  output logic                   busy,
  output logic                   choose,
  output logic [SWEEP_CNT_W-1:0] sweep_cnt,
  output logic [STATE_W-1:0]     state_o
);

  localparam logic [3:0]       AUTO_INIT = 4'(AUTO_SWEEPS);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(CHOOSE_TIMEOUT);

  state_t                 state_q, state_d;
  logic [3:0]             auto_left_q, auto_left_d;
  logic                   single_q, single_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d, tmo_inc;
  logic [SWEEP_CNT_W-1:0] sweep_d;
  logic                   fwd_d;

  logic start_e, prog_e, regr_e, abort_e, finish_e;

  rise_edge u_start_edge  (.clk(clk), .reset(reset), .din(start),       .rise(start_e));
  rise_edge u_prog_edge   (.clk(clk), .reset(reset), .din(progressive), .rise(prog_e));
  rise_edge u_regr_edge   (.clk(clk), .reset(reset), .din(regressive),  .rise(regr_e));
  rise_edge u_abort_edge  (.clk(clk), .reset(reset), .din(abort),       .rise(abort_e));
  rise_edge u_finish_edge (.clk(clk), .reset(reset), .din(finish),      .rise(finish_e));

`ifdef COUNT_SEQ_PAUSE_EN
  logic   pause_e;
  state_t saved_q, saved_d;

  rise_edge u_pause_edge  (.clk(clk), .reset(reset), .din(pause),       .rise(pause_e));
`endif

  assign tmo_inc = tmo_q + TMO_W'(1);

  // Next-state decision. Abort is checked first in every active state so
  // it beats any simultaneous finish, selection or pause edge.
  always_comb begin
    state_d     = state_q;
    auto_left_d = auto_left_q;
    single_d    = single_q;
    tmo_d       = tmo_q;
    sweep_d     = sweep_cnt;
`ifdef COUNT_SEQ_PAUSE_EN
    saved_d     = saved_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_e) begin
          state_d     = UP;
          sweep_d     = '0;
          auto_left_d = AUTO_INIT;
          single_d    = 1'b0;
        end
      end

      UP, DOWN: begin
        if (abort_e) begin
          state_d = IDLE;
`ifdef COUNT_SEQ_PAUSE_EN
        end else if (pause_e) begin
          saved_d = state_q;
          state_d = PAUSED;
`endif
        end else if (finish_e) begin
          sweep_d = sat_inc(sweep_cnt);
          if (single_q) begin
            state_d = IDLE;
          end else begin
            auto_left_d = auto_left_q - 4'd1;
            if (auto_left_q == 4'd1) begin
              state_d = CHOOSE;
              tmo_d   = '0;
            end else begin
              state_d = (state_q == UP) ? DOWN : UP;
            end
          end
        end
      end

      CHOOSE: begin
        if (abort_e) begin
          state_d = IDLE;
        end else if (prog_e) begin
          state_d  = UP;
          single_d = 1'b1;
        end else if (regr_e) begin
          state_d  = DOWN;
          single_d = 1'b1;
        end else if (CHOOSE_TIMEOUT != 0) begin
          // Leave on the cycle the count reaches the limit, so IDLE shows
          // exactly CHOOSE_TIMEOUT clks after entering CHOOSE.
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_LIMIT) begin
            state_d = IDLE;
          end
        end
      end

`ifdef COUNT_SEQ_PAUSE_EN
      PAUSED: begin
        if (abort_e) begin
          state_d = IDLE;
        end else if (pause_e) begin
          state_d = saved_q;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // Direction follows the sweep state; CHOOSE and PAUSED keep whatever
  // direction the counter last ran in.
  always_comb begin
    case (state_d)
      UP:      fwd_d = 1'b1;
      DOWN:    fwd_d = 1'b0;
      IDLE:    fwd_d = 1'b0;
      default: fwd_d = forward;
    endcase
  end

  // State and all outputs are registered from the next-state values so the
  // outputs change one clk after the edge that caused the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      auto_left_q <= '0;
      single_q    <= 1'b0;
      tmo_q       <= '0;
      sweep_cnt   <= '0;
      enable      <= 1'b0;
      forward     <= 1'b0;
      busy        <= 1'b0;
      choose      <= 1'b0;
      state_o     <= '0;
`ifdef COUNT_SEQ_PAUSE_EN
      saved_q     <= IDLE;
`endif
    end else begin
      state_q     <= state_d;
      auto_left_q <= auto_left_d;
      single_q    <= single_d;
      tmo_q       <= tmo_d;
      sweep_cnt   <= sweep_d;
      enable      <= (state_d == UP) || (state_d == DOWN);
      forward     <= fwd_d;
      busy        <= (state_d != IDLE);
      choose      <= (state_d == CHOOSE);
      state_o     <= state_d;
`ifdef COUNT_SEQ_PAUSE_EN
      saved_q     <= saved_d;
`endif
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  localparam int AUTO = 2;
  localparam int TMO1 = 10;
`ifdef COUNT_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, progressive, regressive, abort, pause, finish;

  logic       en0, fwd0, busy0, ch0;
  logic [7:0] sw0;
  logic [2:0] st0;
  logic       en1, fwd1, busy1, ch1;
  logic [7:0] sw1;
  logic [2:0] st1;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  // dut0: no CHOOSE timeout; dut1: CHOOSE timeout of TMO1 clks.
  count_sequencer #(.AUTO_SWEEPS(AUTO), .CHOOSE_TIMEOUT(0), .TMO_W(32)) dut0 (
    .clk(clk), .reset(reset), .start(start), .progressive(progressive),
    .regressive(regressive), .abort(abort),
`ifdef COUNT_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .finish(finish), .enable(en0), .forward(fwd0), .busy(busy0),
    .choose(ch0), .sweep_cnt(sw0), .state_o(st0));

  count_sequencer #(.AUTO_SWEEPS(AUTO), .CHOOSE_TIMEOUT(TMO1), .TMO_W(32)) dut1 (
    .clk(clk), .reset(reset), .start(start), .progressive(progressive),
    .regressive(regressive), .abort(abort),
`ifdef COUNT_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .finish(finish), .enable(en1), .forward(fwd1), .busy(busy1),
    .choose(ch1), .sweep_cnt(sw1), .state_o(st1));

  // Behavioural reference: activity flags rather than a state code.
  typedef struct {
    bit running;
    bit dirUp;
    bit choosing;
    bit paused;
    bit fwd;
    bit single;
    int sweeps;
    int left;
    int waited;
  } model_t;

  model_t m0, m1;
  bit pSt, pPr, pRg, pAb, pFi, pPa;

  function automatic model_t clearModel();
    model_t z;
    z.running = 0; z.dirUp = 0; z.choosing = 0; z.paused = 0; z.fwd = 0;
    z.single = 0; z.sweeps = 0; z.left = 0; z.waited = 0;
    return z;
  endfunction

  function automatic model_t step(model_t m, int tmo, bit st, bit pr, bit rg,
                                  bit ab, bit fi, bit pa);
    model_t n = m;
    if (!m.running && !m.choosing) begin
      if (st) begin
        n.running = 1; n.dirUp = 1; n.fwd = 1; n.paused = 0;
        n.sweeps = 0; n.left = AUTO; n.single = 0;
      end
    end else if (ab) begin
      n.running = 0; n.choosing = 0; n.paused = 0; n.fwd = 0;
    end else if (m.choosing) begin
      if (pr) begin
        n.choosing = 0; n.running = 1; n.dirUp = 1; n.fwd = 1; n.single = 1;
      end else if (rg) begin
        n.choosing = 0; n.running = 1; n.dirUp = 0; n.fwd = 0; n.single = 1;
      end else if (tmo != 0) begin
        n.waited = m.waited + 1;
        if (n.waited == tmo) begin
          n.choosing = 0; n.fwd = 0;
        end
      end
    end else if (m.paused) begin
      if (pa) n.paused = 0;
    end else if (pa) begin
      n.paused = 1;
    end else if (fi) begin
      n.sweeps = (m.sweeps < 255) ? m.sweeps + 1 : 255;
      if (m.single) begin
        n.running = 0; n.fwd = 0;
      end else begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.running = 0; n.choosing = 1; n.waited = 0;
        end else begin
          n.dirUp = !m.dirUp; n.fwd = n.dirUp;
        end
      end
    end
    return n;
  endfunction

  function automatic int modelState(model_t m);
    if (m.choosing) return 3;
    if (!m.running) return 0;
    if (m.paused) return 4;
    return m.dirUp ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m0 = clearModel();
      m1 = clearModel();
      {pSt, pPr, pRg, pAb, pFi, pPa} = '0;
    end else begin
      bit eSt, ePr, eRg, eAb, eFi, ePa;
      eSt = start && !pSt;
      ePr = progressive && !pPr;
      eRg = regressive && !pRg;
      eAb = abort && !pAb;
      eFi = finish && !pFi;
      ePa = PAUSE_EN && pause && !pPa;
      m0 = step(m0, 0, eSt, ePr, eRg, eAb, eFi, ePa);
      m1 = step(m1, TMO1, eSt, ePr, eRg, eAb, eFi, ePa);
      {pSt, pPr, pRg, pAb, pFi, pPa} = {start, progressive, regressive, abort, finish, pause};
    end
  end

  task automatic checkVal(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("d0.enable",  en0,   m0.running && !m0.paused);
    checkVal("d0.forward", fwd0,  m0.fwd);
    checkVal("d0.busy",    busy0, m0.running || m0.choosing);
    checkVal("d0.choose",  ch0,   m0.choosing);
    checkVal("d0.sweep",   sw0,   m0.sweeps);
    checkVal("d0.state",   st0,   modelState(m0));
    checkVal("d1.enable",  en1,   m1.running && !m1.paused);
    checkVal("d1.forward", fwd1,  m1.fwd);
    checkVal("d1.busy",    busy1, m1.running || m1.choosing);
    checkVal("d1.choose",  ch1,   m1.choosing);
    checkVal("d1.sweep",   sw1,   m1.sweeps);
    checkVal("d1.state",   st1,   modelState(m1));
  endtask

  // Drive one cycle of inputs, let one posedge pass, check at the negedge.
  task automatic applyStimulus(input bit st, input bit pr, input bit rg,
                               input bit ab, input bit fi, input bit pa);
    start = st; progressive = pr; regressive = rg;
    abort = ab; finish = fi; pause = pa;
    @(negedge clk);
    checkOutput();
  endtask

  typedef struct {
    bit st, pr, rg, ab, fi;
    bit en, fwd, busy, ch;
    int sw;
    int state;
  } vec_t;

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{1,0,0,0,0, 1,1,1,0, 0,1};
    vecs[1]  = '{0,0,0,0,0, 1,1,1,0, 0,1};
    vecs[2]  = '{0,0,0,0,1, 1,0,1,0, 1,2};
    vecs[3]  = '{0,0,0,0,0, 1,0,1,0, 1,2};
    vecs[4]  = '{0,0,0,0,1, 0,0,1,1, 2,3};
    vecs[5]  = '{0,0,0,0,0, 0,0,1,1, 2,3};
    vecs[6]  = '{0,0,1,0,0, 1,0,1,0, 2,2};
    vecs[7]  = '{0,0,0,0,0, 1,0,1,0, 2,2};
    vecs[8]  = '{0,0,0,0,1, 0,0,0,0, 3,0};
    vecs[9]  = '{0,0,0,0,0, 0,0,0,0, 3,0};
    vecs[10] = '{1,0,0,0,0, 1,1,1,0, 0,1};
    vecs[11] = '{0,0,0,0,1, 1,0,1,0, 1,2};
    vecs[12] = '{0,0,0,0,0, 1,0,1,0, 1,2};
    vecs[13] = '{0,0,0,0,1, 0,0,1,1, 2,3};
    vecs[14] = '{0,1,1,0,0, 1,1,1,0, 2,1};
    vecs[15] = '{0,0,0,1,0, 0,0,0,0, 2,0};
    vecs[16] = '{1,0,0,0,1, 1,1,1,0, 0,1};
    vecs[17] = '{0,0,0,0,0, 1,1,1,0, 0,1};
    vecs[18] = '{1,0,0,0,0, 1,1,1,0, 0,1};
    vecs[19] = '{0,1,0,0,0, 1,1,1,0, 0,1};
    vecs[20] = '{0,0,0,1,0, 0,0,0,0, 0,0};
    vecs[21] = '{0,0,0,0,0, 0,0,0,0, 0,0};

    reset = 1'b1;
    {start, progressive, regressive, abort, finish, pause} = '0;
    repeat (3) @(negedge clk);
    checkOutput();
    checkVal("reset.state", st0, 0);
    checkVal("reset.busy", busy0, 0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].st, vecs[i].pr, vecs[i].rg, vecs[i].ab, vecs[i].fi, 1'b0);
      checkVal($sformatf("vec%0d.enable", i),  en0,   vecs[i].en);
      checkVal($sformatf("vec%0d.forward", i), fwd0,  vecs[i].fwd);
      checkVal($sformatf("vec%0d.busy", i),    busy0, vecs[i].busy);
      checkVal($sformatf("vec%0d.choose", i),  ch0,   vecs[i].ch);
      checkVal($sformatf("vec%0d.sweep", i),   sw0,   vecs[i].sw);
      checkVal($sformatf("vec%0d.state", i),   st0,   vecs[i].state);
    end

    // finish held high across UP->DOWN counts only once
    applyStimulus(1,0,0,0,0,0);
    applyStimulus(0,0,0,0,1,0);
    repeat (4) applyStimulus(0,0,0,0,1,0);
    checkVal("heldFinish.state", st0, 2);
    checkVal("heldFinish.sweep", sw0, 1);
    applyStimulus(0,0,0,0,0,0);
    applyStimulus(0,0,0,0,1,0);
    checkVal("refinish.state", st0, 3);
    checkVal("refinish.sweep", sw0, 2);

    // CHOOSE timeout: dut1 leaves exactly TMO1 clks after entering
    for (int k = 1; k < TMO1; k++) begin
      applyStimulus(0,0,0,0,0,0);
      checkVal($sformatf("tmoWait%0d.state", k), st1, 3);
    end
    applyStimulus(0,0,0,0,0,0);
    checkVal("tmoExpire.state", st1, 0);
    checkVal("tmoExpire.busy", busy1, 0);
    checkVal("noTimeout.state", st0, 3);
    applyStimulus(0,0,0,1,0,0);
    checkVal("abortChoose.state", st0, 0);

    // abort during DOWN holds sweep_cnt
    applyStimulus(1,0,0,0,0,0);
    applyStimulus(0,0,0,0,1,0);
    applyStimulus(0,0,0,1,0,0);
    checkVal("abortDown.state", st0, 0);
    checkVal("abortDown.sweep", sw0, 1);
    checkVal("abortDown.enable", en0, 0);

    // reset mid-sweep wins over simultaneous inputs
    applyStimulus(1,0,0,0,0,0);
    applyStimulus(0,0,0,0,1,0);
    reset = 1'b1;
    applyStimulus(1,1,0,0,1,0);
    checkVal("midReset.state", st0, 0);
    checkVal("midReset.sweep", sw0, 0);
    checkVal("midReset.forward", fwd0, 0);
    reset = 1'b0;
    applyStimulus(0,0,0,0,0,0);

`ifdef COUNT_SEQ_PAUSE_EN
    applyStimulus(1,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,1);
    checkVal("pause.state", st0, 4);
    checkVal("pause.enable", en0, 0);
    checkVal("pause.forward", fwd0, 1);
    applyStimulus(0,0,0,0,0,0);
    applyStimulus(0,0,0,0,1,0);
    applyStimulus(0,0,0,0,0,0);
    checkVal("pausedFinish.sweep", sw0, 0);
    checkVal("pausedFinish.state", st0, 4);
    applyStimulus(0,0,0,0,0,1);
    checkVal("resume.state", st0, 1);
    checkVal("resume.forward", fwd0, 1);
    applyStimulus(0,0,0,0,0,0);
    applyStimulus(0,0,0,0,0,1);
    reset = 1'b1;
    applyStimulus(0,0,0,0,0,0);
    checkVal("pausedReset.state", st0, 0);
    checkVal("pausedReset.enable", en0, 0);
    checkVal("pausedReset.busy", busy0, 0);
    reset = 1'b0;
`endif

    // randomized levels against the reference model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 10);
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Sequencing controller for the 7-segment up/down counter datapath: drives the counter's `enable` and `forward` controls and runs a start → alternating automatic sweeps → user-choice → single-sweep cycle. It sits between the debounced user buttons and the counter. It is the only block that decides when the counter runs and in which direction. It reacts to the counter's `finish` flag, which comes from a slower counter clock, by rising-edge detection only.

## Interface
- AUTO_SWEEPS, 2, number of alternating sweeps (UP first) after start before entering CHOOSE; legal range 1..15.
- CHOOSE_TIMEOUT, 0, clk cycles allowed in CHOOSE without a selection before returning to IDLE; 0 disables the timeout.
- TMO_W, 32, width of the timeout counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  debounced start button, level.
- progressive  in  1  debounced "count up" selection, level.
- regressive  in  1  debounced "count down" selection, level.
- abort  in  1  debounced stop button, level.
- pause  in  1  debounced pause toggle, level; present only with COUNT_SEQ_PAUSE_EN.
- finish  in  1  counter terminal flag, level, may stay high for many clk cycles.
- enable  out  1  counter run enable.
- forward  out  1  1 = count up, 0 = count down.
- busy  out  1  high in any state other than IDLE.
- choose  out  1  high in CHOOSE; used to light the "select direction" indicator.
- sweep_cnt  out  8  completed sweeps since the last start; saturates at 255.
- state_o  out  3  current state encoding, for debug.

## Operation
- All button and `finish` inputs are edge-detected: edge = input high now AND low at the previous clk. Edge registers reset to 0 and update every cycle in every state.
- IDLE (0): enable=0, forward=0. On a start edge: go to UP, clear sweep_cnt, set auto_left=AUTO_SWEEPS, clear the single flag.
- UP (1): enable=1, forward=1. DOWN (2): enable=1, forward=0.
- On a finish edge in UP/DOWN: sweep_cnt+1 (saturating), then:
  - if single: go to IDLE;
  - else decrement auto_left; if it reaches 0, go to CHOOSE; otherwise go to the opposite direction.
- CHOOSE (3): enable=0, forward holds its last value.
  - progressive edge: go to UP with single=1.
  - regressive edge: go to DOWN with single=1.
  - Both edges in the same cycle: progressive wins.
  - Timeout counter clears on entry. When it reaches CHOOSE_TIMEOUT (if nonzero): go to IDLE.
- Abort edge in any non-IDLE state: go to IDLE. Abort has priority over every other event except reset. sweep_cnt is held, not cleared.
- A start edge outside IDLE is ignored. Selection edges outside CHOOSE are ignored.

## Timing
- Reset values: state IDLE, enable 0, forward 0, busy 0, choose 0, sweep_cnt 0, state_o 0, auto_left 0, single 0, timeout counter 0.
- All outputs are registered. Latency is 1 clk from the posedge that samples an edge to the new outputs.
- If finish is already high when a sweep state is entered, it does not count. A new low→high transition is required.
- Finish edges outside UP/DOWN are ignored.
- Reset asserted mid-sweep returns to IDLE on the same edge, regardless of the other inputs.

## Configuration
- Macro: COUNT_SEQ_PAUSE_EN.
- Defined:
  - adds the `pause` port and state PAUSED (4): enable=0, forward holds.
  - A pause edge in UP/DOWN saves the state and enters PAUSED.
  - A pause edge in PAUSED returns to the saved state.
  - Finish edges are ignored in PAUSED; abort still goes to IDLE.
- Undefined: no `pause` port, no PAUSED state, state encoding limited to 0..3 (state_o[2] tied 0).

## Structure
- Package count_seq_pkg: state encoding constants (IDLE, UP, DOWN, CHOOSE, PAUSED), STATE_W=3, SWEEP_CNT_W=8.
- Sub-module rise_edge: one-register rising-edge detector, instantiated once per button input and once for finish.
- Next-state logic and registered outputs live in count_sequencer.

## Test plan
- Reset, then start pulse:
  - → enable=1, forward=1 one clk after the edge.
  - After 2 finish pulses → forward=0, then choose=1, enable=0, sweep_cnt=2.
- In CHOOSE, regressive pulse → DOWN (enable=1, forward=0). Next finish pulse → IDLE, sweep_cnt=3, busy=0.
- progressive and regressive rise in the same cycle in CHOOSE → UP.
- finish held high across the UP→DOWN transition → no second count until finish falls and rises again.
- Abort during DOWN → IDLE next clk with sweep_cnt unchanged. CHOOSE_TIMEOUT=10 with no input → IDLE exactly 10 clks after entering CHOOSE.
- With COUNT_SEQ_PAUSE_EN:
  - pause pulse in UP → enable=0, and finish pulses are ignored;
  - a second pause pulse → back to UP, forward=1;
  - reset asserted while PAUSED → IDLE with all outputs 0.
